// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding, feeding the 32-bit ALU.
// Captures decoded operands/control each cycle, resolves RAW hazards from the
// EX/MEM and MEM/WB result buses, and honours hazard-unit stall/flush.
//
// Ports:
//   clk, reset (async, active-low)
//   Stall, Flush                 hazard-unit control (Flush wins)
//   ValidIn, ALUOperationIn, ReadData1, ReadData2, Immediate, ALUSrc,
//   ShamtIn, RsIn, RtIn, WriteRegIn, RegWriteIn      decode-stage inputs
//   ExMem{RegWrite,WriteReg,Result}, MemWb{RegWrite,WriteReg,Result}
//                                forwarding sources
//   ValidOut, ALUOperation, A, B, Shamt, StoreData, WriteReg, RegWrite,
//   ForwardA, ForwardB           EX-stage outputs (A/B/StoreData/Forward*
//                                are combinational off the stored fields)
module id_ex_operand_stage #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned OP_WIDTH       = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      Stall,
  input  logic                      Flush,
  input  logic                      ValidIn,
  input  logic [OP_WIDTH-1:0]       ALUOperationIn,
  input  logic [DATA_WIDTH-1:0]     ReadData1,
  input  logic [DATA_WIDTH-1:0]     ReadData2,
  input  logic [DATA_WIDTH-1:0]     Immediate,
  input  logic                      ALUSrc,
  input  logic [4:0]                ShamtIn,
  input  logic [REG_ADDR_WIDTH-1:0] RsIn,
  input  logic [REG_ADDR_WIDTH-1:0] RtIn,
  input  logic [REG_ADDR_WIDTH-1:0] WriteRegIn,
  input  logic                      RegWriteIn,
  input  logic                      ExMemRegWrite,
  input  logic [REG_ADDR_WIDTH-1:0] ExMemWriteReg,
  input  logic [DATA_WIDTH-1:0]     ExMemResult,
  input  logic                      MemWbRegWrite,
  input  logic [REG_ADDR_WIDTH-1:0] MemWbWriteReg,
  input  logic [DATA_WIDTH-1:0]     MemWbResult,
  output logic                      ValidOut,
  output logic [OP_WIDTH-1:0]       ALUOperation,
  output logic [DATA_WIDTH-1:0]     A,
  output logic [DATA_WIDTH-1:0]     B,
  output logic [4:0]                Shamt,
  output logic [DATA_WIDTH-1:0]     StoreData,
  output logic [REG_ADDR_WIDTH-1:0] WriteReg,
  output logic                      RegWrite,
  output logic [1:0]                ForwardA,
  output logic [1:0]                ForwardB
);

  localparam logic [1:0] FWD_NONE  = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  // Stored pipeline fields
  logic                      r_valid;
  logic [OP_WIDTH-1:0]       r_op;
  logic [DATA_WIDTH-1:0]     r_rs_data;
  logic [DATA_WIDTH-1:0]     r_rt_data;
  logic [DATA_WIDTH-1:0]     r_imm;
  logic                      r_alu_src;
  logic [4:0]                r_shamt;
  logic [REG_ADDR_WIDTH-1:0] r_rs;
  logic [REG_ADDR_WIDTH-1:0] r_rt;
  logic [REG_ADDR_WIDTH-1:0] r_write_reg;
  logic                      r_reg_write;

  logic                      w_rs_exmem;
  logic                      w_rs_memwb;
  logic                      w_rt_exmem;
  logic                      w_rt_memwb;
  logic [DATA_WIDTH-1:0]     w_fwd_rs;
  logic [DATA_WIDTH-1:0]     w_fwd_rt;
  logic [1:0]                w_fwd_a;
  logic [1:0]                w_fwd_b;

  // Hazard match terms; $zero never forwards and bubbles never forward
  assign w_rs_exmem = r_valid && ExMemRegWrite && (ExMemWriteReg == r_rs) &&
                      (r_rs != '0);
  assign w_rs_memwb = r_valid && MemWbRegWrite && (MemWbWriteReg == r_rs) &&
                      (r_rs != '0);
  assign w_rt_exmem = r_valid && ExMemRegWrite && (ExMemWriteReg == r_rt) &&
                      (r_rt != '0);
  assign w_rt_memwb = r_valid && MemWbRegWrite && (MemWbWriteReg == r_rt) &&
                      (r_rt != '0);

  // Operand muxes: EX/MEM is the younger producer so it takes priority
  always_comb begin
    w_fwd_rs = r_rs_data;
    w_fwd_a  = FWD_NONE;
    w_fwd_rt = r_rt_data;
    w_fwd_b  = FWD_NONE;
    if (w_rs_exmem) begin
      w_fwd_rs = ExMemResult;
      w_fwd_a  = FWD_EXMEM;
    end else if (w_rs_memwb) begin
      w_fwd_rs = MemWbResult;
      w_fwd_a  = FWD_MEMWB;
    end
    if (w_rt_exmem) begin
      w_fwd_rt = ExMemResult;
      w_fwd_b  = FWD_EXMEM;
    end else if (w_rt_memwb) begin
      w_fwd_rt = MemWbResult;
      w_fwd_b  = FWD_MEMWB;
    end
  end

  // Pipeline register: flush beats stall; a stall captures forwarded operands
  // so a value survives after its producer retires from MEM/WB.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid     <= 1'b0;
      r_op        <= '0;
      r_rs_data   <= '0;
      r_rt_data   <= '0;
      r_imm       <= '0;
      r_alu_src   <= 1'b0;
      r_shamt     <= '0;
      r_rs        <= '0;
      r_rt        <= '0;
      r_write_reg <= '0;
      r_reg_write <= 1'b0;
    end else if (Flush) begin
      r_valid     <= 1'b0;
      r_op        <= '0;
      r_rs_data   <= '0;
      r_rt_data   <= '0;
      r_imm       <= '0;
      r_alu_src   <= 1'b0;
      r_shamt     <= '0;
      r_rs        <= '0;
      r_rt        <= '0;
      r_write_reg <= '0;
      r_reg_write <= 1'b0;
    end else if (Stall) begin
      if (r_valid) begin
        r_rs_data <= w_fwd_rs;
        r_rt_data <= w_fwd_rt;
      end
    end else begin
      r_valid     <= ValidIn;
      r_op        <= ALUOperationIn;
      r_rs_data   <= ReadData1;
      r_rt_data   <= ReadData2;
      r_imm       <= Immediate;
      r_alu_src   <= ALUSrc;
      r_shamt     <= ShamtIn;
      r_rs        <= RsIn;
      r_rt        <= RtIn;
      r_write_reg <= WriteRegIn;
      r_reg_write <= RegWriteIn;
    end
  end

  // EX-stage outputs
  assign ValidOut     = r_valid;
  assign ALUOperation = r_op;
  assign A            = w_fwd_rs;
  assign StoreData    = w_fwd_rt;
  assign B            = r_alu_src ? r_imm : w_fwd_rt;
  assign Shamt        = r_shamt;
  assign WriteReg     = r_write_reg;
  assign RegWrite     = r_reg_write & r_valid;
  assign ForwardA     = w_fwd_a;
  assign ForwardB     = w_fwd_b;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed scoreboard bench for id_ex_operand_stage.
module tb_id_ex_operand_stage;

  logic        clk;
  logic        reset;
  logic        Stall, Flush, ValidIn, ALUSrc, RegWriteIn;
  logic [3:0]  ALUOperationIn;
  logic [31:0] ReadData1, ReadData2, Immediate;
  logic [4:0]  ShamtIn, RsIn, RtIn, WriteRegIn;
  logic        ExMemRegWrite, MemWbRegWrite;
  logic [4:0]  ExMemWriteReg, MemWbWriteReg;
  logic [31:0] ExMemResult, MemWbResult;
  logic        ValidOut, RegWrite;
  logic [3:0]  ALUOperation;
  logic [31:0] A, B, StoreData;
  logic [4:0]  Shamt, WriteReg;
  logic [1:0]  ForwardA, ForwardB;

  id_ex_operand_stage dut (
    .clk(clk), .reset(reset), .Stall(Stall), .Flush(Flush),
    .ValidIn(ValidIn), .ALUOperationIn(ALUOperationIn),
    .ReadData1(ReadData1), .ReadData2(ReadData2), .Immediate(Immediate),
    .ALUSrc(ALUSrc), .ShamtIn(ShamtIn), .RsIn(RsIn), .RtIn(RtIn),
    .WriteRegIn(WriteRegIn), .RegWriteIn(RegWriteIn),
    .ExMemRegWrite(ExMemRegWrite), .ExMemWriteReg(ExMemWriteReg),
    .ExMemResult(ExMemResult), .MemWbRegWrite(MemWbRegWrite),
    .MemWbWriteReg(MemWbWriteReg), .MemWbResult(MemWbResult),
    .ValidOut(ValidOut), .ALUOperation(ALUOperation), .A(A), .B(B),
    .Shamt(Shamt), .StoreData(StoreData), .WriteReg(WriteReg),
    .RegWrite(RegWrite), .ForwardA(ForwardA), .ForwardB(ForwardB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic expect_v(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty: observed=%h expected=<none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        bad++;
        $error("FAIL %s: observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic id(input logic v, input logic [3:0] op, input logic [31:0] d1,
                    input logic [31:0] d2, input logic [31:0] im,
                    input logic src, input logic [4:0] sh, input logic [4:0] rs,
                    input logic [4:0] rt, input logic [4:0] wr,
                    input logic rw);
    ValidIn = v; ALUOperationIn = op; ReadData1 = d1; ReadData2 = d2;
    Immediate = im; ALUSrc = src; ShamtIn = sh; RsIn = rs; RtIn = rt;
    WriteRegIn = wr; RegWriteIn = rw;
  endtask

  task automatic fwd_off();
    ExMemRegWrite = 1'b0; ExMemWriteReg = 5'd0; ExMemResult = 32'h0;
    MemWbRegWrite = 1'b0; MemWbWriteReg = 5'd0; MemWbResult = 32'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; Stall = 1'b0; Flush = 1'b0;
    id(1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    fwd_off();

    // Reset state
    #2;
    expect_v("rst_valid", 32'h0); expect_v("rst_A", 32'h0);
    expect_v("rst_B", 32'h0); expect_v("rst_fwdA", 32'h0);
    expect_v("rst_fwdB", 32'h0); expect_v("rst_regwrite", 32'h0);
    check(32'(ValidOut)); check(A); check(B);
    check(32'(ForwardA)); check(32'(ForwardB)); check(32'(RegWrite));
    @(negedge clk);
    reset = 1'b1;

    // Basic load: ADD 5,7
    id(1'b1, 4'b0011, 32'h5, 32'h7, 32'h0, 1'b0, 5'd3, 5'd1, 5'd2, 5'd4, 1'b1);
    expect_v("basic_A", 32'h5); expect_v("basic_B", 32'h7);
    expect_v("basic_valid", 32'h1); expect_v("basic_fwdA", 32'h0);
    expect_v("basic_fwdB", 32'h0); expect_v("basic_op", 32'h3);
    expect_v("basic_shamt", 32'h3); expect_v("basic_wreg", 32'h4);
    expect_v("basic_regwrite", 32'h1); expect_v("basic_store", 32'h7);
    tick();
    check(A); check(B); check(32'(ValidOut)); check(32'(ForwardA));
    check(32'(ForwardB)); check(32'(ALUOperation)); check(32'(Shamt));
    check(32'(WriteReg)); check(32'(RegWrite)); check(StoreData);

    // Reset mid-op, between edges, with Stall also high
    Stall = 1'b1;
    reset = 1'b0;
    expect_v("midrst_valid", 32'h0); expect_v("midrst_A", 32'h0);
    expect_v("midrst_op", 32'h0); expect_v("midrst_regwrite", 32'h0);
    #1;
    check(32'(ValidOut)); check(A); check(32'(ALUOperation)); check(32'(RegWrite));
    #1;
    reset = 1'b1;
    Stall = 1'b0;

    // Forward priority on rs=8
    id(1'b1, 4'b0011, 32'h11, 32'h7, 32'h0, 1'b0, 5'd0, 5'd8, 5'd2, 5'd5, 1'b1);
    tick();
    ExMemRegWrite = 1'b1; ExMemWriteReg = 5'd8; ExMemResult = 32'h100;
    MemWbRegWrite = 1'b1; MemWbWriteReg = 5'd8; MemWbResult = 32'h200;
    expect_v("prio_A_exmem", 32'h100); expect_v("prio_fwdA_exmem", 32'h2);
    expect_v("prio_fwdB_none", 32'h0);
    #1;
    check(A); check(32'(ForwardA)); check(32'(ForwardB));
    ExMemRegWrite = 1'b0;
    expect_v("prio_A_memwb", 32'h200); expect_v("prio_fwdA_memwb", 32'h1);
    #1;
    check(A); check(32'(ForwardA));
    MemWbRegWrite = 1'b0;
    expect_v("prio_A_stored", 32'h11); expect_v("prio_fwdA_none", 32'h0);
    #1;
    check(A); check(32'(ForwardA));

    // $zero guard on both operands
    fwd_off();
    id(1'b1, 4'b0011, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd6, 1'b1);
    tick();
    ExMemRegWrite = 1'b1; ExMemWriteReg = 5'd0; ExMemResult = 32'hFFFF_FFFF;
    expect_v("zero_A", 32'h0); expect_v("zero_fwdA", 32'h0);
    expect_v("zero_B", 32'h0); expect_v("zero_fwdB", 32'h0);
    #1;
    check(A); check(32'(ForwardA)); check(B); check(32'(ForwardB));

    // Stall refresh: rt=9 with immediate B
    fwd_off();
    id(1'b1, 4'b0011, 32'h1, 32'h22, 32'h10, 1'b1, 5'd0, 5'd1, 5'd9, 5'd7, 1'b1);
    tick();
    Stall = 1'b1;
    MemWbRegWrite = 1'b1; MemWbWriteReg = 5'd9; MemWbResult = 32'h55;
    expect_v("stall1_B", 32'h10); expect_v("stall1_store", 32'h55);
    expect_v("stall1_fwdB", 32'h1);
    #1;
    check(B); check(StoreData); check(32'(ForwardB));
    tick();
    MemWbWriteReg = 5'd3;
    id(1'b1, 4'b0111, 32'h99, 32'hDEAD, 32'h77, 1'b0, 5'd0, 5'd9, 5'd9, 5'd9, 1'b1);
    expect_v("stall2_B", 32'h10); expect_v("stall2_store", 32'h55);
    expect_v("stall2_fwdB", 32'h0); expect_v("stall2_op_hold", 32'h3);
    expect_v("stall2_A_hold", 32'h1);
    #1;
    check(B); check(StoreData); check(32'(ForwardB)); check(32'(ALUOperation)); check(A);
    MemWbRegWrite = 1'b0;
    tick();
    expect_v("stall3_store", 32'h55);
    check(StoreData);

    // Flush over stall with a valid SUB held
    Stall = 1'b0;
    fwd_off();
    id(1'b1, 4'b0100, 32'h9, 32'h3, 32'h0, 1'b0, 5'd0, 5'd10, 5'd11, 5'd12, 1'b1);
    tick();
    expect_v("sub_op", 32'h4); expect_v("sub_valid", 32'h1);
    check(32'(ALUOperation)); check(32'(ValidOut));
    Stall = 1'b1; Flush = 1'b1;
    tick();
    expect_v("flush_valid", 32'h0); expect_v("flush_regwrite", 32'h0);
    expect_v("flush_op", 32'h0); expect_v("flush_A", 32'h0);
    expect_v("flush_B", 32'h0); expect_v("flush_store", 32'h0);
    check(32'(ValidOut)); check(32'(RegWrite)); check(32'(ALUOperation));
    check(A); check(B); check(StoreData);
    Stall = 1'b0; Flush = 1'b0;

    // Invalid instruction: no forwarding, RegWrite gated
    id(1'b0, 4'b0001, 32'h33, 32'h44, 32'h0, 1'b0, 5'd0, 5'd8, 5'd8, 5'd8, 1'b1);
    tick();
    ExMemRegWrite = 1'b1; ExMemWriteReg = 5'd8; ExMemResult = 32'hABCD;
    expect_v("inv_A", 32'h33); expect_v("inv_fwdA", 32'h0);
    expect_v("inv_regwrite", 32'h0);
    #1;
    check(A); check(32'(ForwardA)); check(32'(RegWrite));
    fwd_off();

    // Back-to-back loads, one per cycle
    for (int i = 0; i < 4; i++) begin
      id(1'b1, 4'(i), 32'(i * 3 + 1), 32'(i + 100), 32'h0, 1'b0, 5'(i), 5'd1,
         5'd2, 5'(i + 1), 1'b1);
      expect_v("b2b_A", 32'(i * 3 + 1));
      expect_v("b2b_B", 32'(i + 100));
      expect_v("b2b_wreg", 32'(i + 1));
      tick();
      check(A); check(B); check(32'(WriteReg));
    end

    total++;
    assert (sb.size() == 0) else begin
      bad++;
      $error("FAIL scoreboard_leftover: observed=%0d expected=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_operand_stage.md
# id_ex_operand_stage

ID/EX pipeline register and operand-forwarding stage sitting directly upstream of the 32-bit ALU in the pipelined MIPS datapath. It captures decoded operands and control from the decode stage each cycle, then drives the ALU's `A`, `B`, `Shamt` and `ALUOperation` inputs. It resolves RAW hazards by forwarding from the EX/MEM and MEM/WB result buses. It supports stall (hold) and flush (bubble) control from the hazard unit.

## Interface
- `DATA_WIDTH`, 32, operand/result width
- `REG_ADDR_WIDTH`, 5, register-file address width
- `OP_WIDTH`, 4, ALU operation code width

Ports:
- `clk`  in  1  clock; all registers update on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `Stall`  in  1  hold current contents (with forward refresh, see Operation)
- `Flush`  in  1  load bubble at next edge; overrides `Stall`
- `ValidIn`  in  1  decode stage presents a real instruction
- `ALUOperationIn`  in  4  ALU opcode (AND 0000, OR 0001, NOR 0010, ADD 0011, SUB 0100, LUI 0101, SLL 0110, SRL 0111)
- `ReadData1`, `ReadData2`  in  32  register-file rs / rt data
- `Immediate`  in  32  sign/zero-extended immediate
- `ALUSrc`  in  1  1: B = immediate, 0: B = rt value
- `ShamtIn`  in  5  shift amount
- `RsIn`, `RtIn`, `WriteRegIn`  in  5  source and destination register numbers
- `RegWriteIn`  in  1  instruction writes the register file
- `ExMemRegWrite`, `ExMemWriteReg[4:0]`, `ExMemResult[31:0]`  in  EX/MEM forward source
- `MemWbRegWrite`, `MemWbWriteReg[4:0]`, `MemWbResult[31:0]`  in  MEM/WB forward source
- `ValidOut`  out  1  EX holds a real instruction
- `ALUOperation`  out  4  to ALU
- `A`, `B`  out  32  to ALU (post-forwarding)
- `Shamt`  out  5  to ALU
- `StoreData`  out  32  forwarded rt value, for stores
- `WriteReg`  out  5; `RegWrite`  out  1 (= stored RegWrite AND ValidOut)
- `ForwardA`, `ForwardB`  out  2  00 none, 10 EX/MEM, 01 MEM/WB

## Operation
- Registered fields:
  - valid, opcode, rsData, rtData, imm, ALUSrc, shamt, rs, rt, writeReg, regWrite.
- Edge priority:
  - `reset` low: all fields cleared.
  - else `Flush`: load bubble.
  - else `Stall`: hold and refresh.
  - else load from the ID inputs.
- Bubble:
  - All fields 0.
  - Outputs then read `ValidOut`=0, `RegWrite`=0, `ALUOperation`=0000, `A`=`B`=`StoreData`=0, `ForwardA`=`ForwardB`=00.
- Forwarding is combinational on registered rs/rt, evaluated per operand:
  - EX/MEM match: `ExMemRegWrite` and `ExMemWriteReg`==rs (or rt) and register != 0. Select `ExMemResult`, code 10.
  - Else MEM/WB match under the same rule: select `MemWbResult`, code 01.
  - Else the stored data, code 00.
  - Register 0 is never forwarded.
  - Forwarding is active only when valid=1.
- Operand selection:
  - `A` = fwdRs.
  - `StoreData` = fwdRt.
  - `B` = `ALUSrc` ? imm : fwdRt.
  - `ForwardB` reports the rt selection regardless of `ALUSrc`.
- Stall refresh: on a stall edge with valid=1, rsData ← fwdRs and rtData ← fwdRt. A forwarded value is retained after its producer leaves MEM/WB. All other fields hold.
- No arithmetic; widths pass through unchanged.

## Timing
- Reset value of every output is 0 (`ForwardA`/`ForwardB` = 00). Reset asserts asynchronously and releases on the next edge.
- Latency: ID inputs appear on outputs 1 cycle after a non-stall, non-flush edge.
- Forwarding path is same-cycle: forward-bus changes reach `A`/`B` with no clock.
- `Stall` and `Flush` both high at the same edge: bubble.
- `Flush` with `ValidIn`=1: the instruction is discarded.
- Reset mid-stall: stage becomes a bubble immediately. Stall has no effect until `reset` releases.
- Back-to-back loads with no stall: one instruction per cycle. No bubbles are inserted by this block.

## Test plan
- Reset mid-op:
  - Stimulus: load ReadData1=0x5 with ADD, then pull `reset` low between edges.
  - Response: all outputs 0 immediately, before the next edge.
- Basic load:
  - Stimulus: ReadData1=5, ReadData2=7, ALUSrc=0, ALUOperationIn=0011.
  - Response: next cycle `A`=5, `B`=7, `ValidOut`=1, `ForwardA`=`ForwardB`=00.
- Forward priority:
  - Stimulus: rs=8; EX/MEM writes reg 8 with 0x100; MEM/WB writes reg 8 with 0x200.
  - Response: `A`=0x100, `ForwardA`=10.
  - Drop `ExMemRegWrite`: `A`=0x200, `ForwardA`=01 in the same cycle.
- $zero guard:
  - Stimulus: rs=0, stored rsData=0; EX/MEM writes reg 0 with 0xFFFF_FFFF.
  - Response: `A`=0, `ForwardA`=00.
- Stall refresh:
  - Stimulus: rt=9, ALUSrc=1, imm=0x10. Stall cycle 1 with MEM/WB writing reg 9 = 0x55; cycle 2 MEM/WB writes reg 3.
  - Response: `B`=0x10 throughout; `StoreData`=0x55 in cycle 2 with `ForwardB`=00.
- Flush over stall:
  - Stimulus: valid SUB instruction held; assert `Stall` and `Flush` together.
  - Response: next cycle `ValidOut`=0, `RegWrite`=0, `ALUOperation`=0000, `A`=`B`=0.
